// File: rtl/cia_interrupt_if.sv
// rtl/cia_interrupt_if.sv - CPU-side ICR register access bundle for cia_interrupt
interface cia_interrupt_if;
    logic       phi2_dn;
    logic       icr_w;
    logic       icr_r;
    logic [7:0] data;
    logic [7:0] icr_data;

    modport master (
        output phi2_dn,
        output icr_w,
        output icr_r,
        output data,
        input  icr_data
    );

    modport slave (
        input  phi2_dn,
        input  icr_w,
        input  icr_r,
        input  data,
        output icr_data
    );
endinterface

// File: rtl/cia_interrupt.sv
// rtl/cia_interrupt.sv - CIA interrupt control register: flag latch, mask, IRQ with 6526/8521 timing
module cia_interrupt #(
    parameter bit NEW_CIA = 1'b0
) (
    input  logic             clk,
    input  logic             res,
    cia_interrupt_if.slave   bus,
    input  logic             ta_intr,
    input  logic             tb_intr,
    input  logic             tod_intr,
    input  logic             sp_intr,
    input  logic             flag_n,
    output logic             irq_n
);
    logic [4:0] flags;
    logic [4:0] mask;
    logic       irq_pend;
    logic       flag_prev;

    logic [4:0] sources;
    logic [4:0] flags_next;
    logic [4:0] mask_next;
    logic       hit;
    logic       irq_pend_next;
    logic       data_unused;

    // data[6:5] carry no meaning in the ICR write
    assign data_unused = ^bus.data[6:5];

    always_comb begin
        sources    = {flag_prev & ~flag_n, sp_intr, tod_intr, tb_intr, ta_intr};
        flags_next = (bus.icr_r ? 5'b0 : flags) | sources;
        mask_next  = mask;
        if (bus.icr_w) begin
            if (bus.data[7]) begin
                mask_next = mask | bus.data[4:0];
            end else begin
                mask_next = mask & ~bus.data[4:0];
            end
        end
        hit           = |(flags_next & mask_next);
        // pending is sticky: masking alone never releases it, only a read does
        irq_pend_next = (irq_pend & ~bus.icr_r) | hit;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            flags     <= 5'b0;
            mask      <= 5'b0;
            irq_pend  <= 1'b0;
            irq_n     <= 1'b1;
            flag_prev <= 1'b1;
        end else if (bus.phi2_dn) begin
            flags     <= flags_next;
            mask      <= mask_next;
            irq_pend  <= irq_pend_next;
            flag_prev <= flag_n;
            if (NEW_CIA) begin
                irq_n <= ~irq_pend_next;
            end else begin
                irq_n <= bus.icr_r | ~irq_pend;
            end
        end
    end

    assign bus.icr_data = {~irq_n, 2'b00, flags};
endmodule
